// File: rtl/heat_mode_if.sv
// Heating zone control bus: mode/setpoint/temperature inputs toward the executor and
// heater/fan/status outputs back from it.
interface heat_mode_if #(
    parameter int unsigned TEMP_W = 8
);
    logic              enable;
    logic              selected_mode;
    logic [TEMP_W-1:0] setpoint_eco;
    logic [TEMP_W-1:0] setpoint_comfort;
    logic [TEMP_W-1:0] temp_in;
    logic              temp_valid;
    logic              heater_on;
    logic              fan_on;
    logic [1:0]        state_out;
    logic              mode_ack;
    logic              fault;

    modport master (
        output enable, selected_mode, setpoint_eco, setpoint_comfort, temp_in, temp_valid,
        input  heater_on, fan_on, state_out, mode_ack, fault
    );

    modport slave (
        input  enable, selected_mode, setpoint_eco, setpoint_comfort, temp_in, temp_valid,
        output heater_on, fan_on, state_out, mode_ack, fault
    );
endinterface

// File: rtl/heat_mode_executor.sv
// Per-zone heater/fan controller: mode setpoint select, hysteresis, minimum on/off times.
// Define HEAT_OVERTEMP_EN to add the overtemperature LOCKOUT state and fault flag.
module heat_mode_executor #(
    parameter int unsigned TEMP_W         = 8,
    parameter int unsigned HYST           = 2,
    parameter int unsigned MIN_ON         = 16,
    parameter int unsigned MIN_OFF        = 16,
`ifdef HEAT_OVERTEMP_EN
    parameter int unsigned OVERTEMP_LIMIT = 200,
`endif
    parameter int unsigned FAN_RUNOUT     = 8
) (
    input logic        clk,
    input logic        rst,
    heat_mode_if.slave bus
);
    localparam int unsigned OFF_MAX = (MIN_OFF > FAN_RUNOUT) ? MIN_OFF : FAN_RUNOUT;
    localparam int unsigned CNT_MAX = (MIN_ON > OFF_MAX) ? MIN_ON : OFF_MAX;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  ON_LIM  = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0]  OFF_LIM = CNT_W'(MIN_OFF);
    localparam logic [CNT_W-1:0]  RUN_LIM = CNT_W'(FAN_RUNOUT);
    localparam logic [CNT_W-1:0]  OFF_SAT = CNT_W'(OFF_MAX);
    localparam logic [TEMP_W:0]   HYST_X  = (TEMP_W + 1)'(HYST);

    typedef enum logic [1:0] {
        StOff     = 2'b00,
        StHeat    = 2'b01,
        StRunout  = 2'b10,
        StLockout = 2'b11
    } state_e;

    state_e            state;
    logic              heater_q, fan_q, mode_ack_q, mode_reg;
    logic [CNT_W-1:0]  on_cnt, off_cnt;
    logic [TEMP_W-1:0] sp;
    logic [TEMP_W:0]   temp_x, sp_x;
    logic              cold, hot;

    // One extra bit keeps temp+HYST and sp+HYST from wrapping at the top of the range.
    assign sp     = mode_reg ? bus.setpoint_comfort : bus.setpoint_eco;
    assign temp_x = {1'b0, bus.temp_in};
    assign sp_x   = {1'b0, sp};
    assign cold   = (temp_x + HYST_X) < sp_x;
    assign hot    = temp_x >= (sp_x + HYST_X);

`ifdef HEAT_OVERTEMP_EN
    logic fault_q;
    logic trip;
    assign trip      = bus.temp_valid && (32'(bus.temp_in) > OVERTEMP_LIMIT);
    assign bus.fault = fault_q;
`else
    assign bus.fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StOff;
            heater_q   <= 1'b0;
            fan_q      <= 1'b0;
            mode_ack_q <= 1'b0;
            mode_reg   <= bus.selected_mode;
            on_cnt     <= '0;
            off_cnt    <= OFF_LIM;
`ifdef HEAT_OVERTEMP_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            mode_reg   <= bus.selected_mode;
            mode_ack_q <= bus.selected_mode != mode_reg;

            if (state == StHeat) begin
                if (on_cnt < ON_LIM) on_cnt <= on_cnt + 1'b1;
            end else if (off_cnt < OFF_SAT) begin
                off_cnt <= off_cnt + 1'b1;
            end

`ifdef HEAT_OVERTEMP_EN
            if (trip) begin
                state    <= StLockout;
                heater_q <= 1'b0;
                fan_q    <= 1'b1;
                fault_q  <= 1'b1;
            end else
`endif
            begin
                // Entry clears below override the saturating updates above.
                unique case (state)
                    StOff: begin
                        if (bus.enable && bus.temp_valid && cold && off_cnt >= OFF_LIM) begin
                            state    <= StHeat;
                            heater_q <= 1'b1;
                            fan_q    <= 1'b1;
                            on_cnt   <= '0;
                        end
                    end
                    StHeat: begin
                        if (!bus.enable || (bus.temp_valid && hot && on_cnt >= ON_LIM)) begin
                            state    <= StRunout;
                            heater_q <= 1'b0;
                            fan_q    <= 1'b1;
                            off_cnt  <= '0;
                        end
                    end
                    StRunout: begin
                        if (off_cnt >= RUN_LIM) begin
                            state <= StOff;
                            fan_q <= 1'b0;
                        end
                    end
                    StLockout: begin
                        state <= StLockout;
                    end
                endcase
            end
        end
    end

    assign bus.heater_on = heater_q;
    assign bus.fan_on    = fan_q;
    assign bus.state_out = state;
    assign bus.mode_ack  = mode_ack_q;
endmodule

// File: tb/tb_heat_mode_executor.sv
// Scoreboard bench for heat_mode_executor: expected {state,heater,fan,ack,fault} pushed with
// each stimulus step and popped when the DUT is sampled.
module tb_heat_mode_executor;
    localparam int unsigned TEMP_W     = 8;
    localparam int unsigned MIN_ON     = 16;
    localparam int unsigned MIN_OFF    = 16;
    localparam int unsigned FAN_RUNOUT = 8;

    localparam logic [1:0] S_OFF = 2'b00;
    localparam logic [1:0] S_HEAT = 2'b01;
    localparam logic [1:0] S_RUN = 2'b10;
    localparam logic [1:0] S_LOCK = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    heat_mode_if #(.TEMP_W(TEMP_W)) bus ();

    heat_mode_executor #(
        .TEMP_W    (TEMP_W),
        .MIN_ON    (MIN_ON),
        .MIN_OFF   (MIN_OFF),
        .FAN_RUNOUT(FAN_RUNOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string      name;
        logic [5:0] v;  // {state[1:0], heater, fan, ack, fault}
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    function automatic logic [5:0] obs();
        return {bus.state_out, bus.heater_on, bus.fan_on, bus.mode_ack, bus.fault};
    endfunction

    task automatic push(input string name, input logic [1:0] st, input logic h, input logic f,
                        input logic ack, input logic flt);
        exp_t e;
        e.name = name;
        e.v    = {st, h, f, ack, flt};
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst                  = 1'b1;
        bus.enable           = 1'b1;
        bus.selected_mode    = 1'b0;
        bus.setpoint_eco     = 8'd40;
        bus.setpoint_comfort = 8'd50;
        bus.temp_in          = 8'd30;
        bus.temp_valid       = 1'b1;
        push("reset_values", S_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        e = exp_q.pop_front();
        total++;
        if (obs() !== e.v) begin
            bad++;
            $display("FAIL %s: got %b want %b (st,h,f,ack,flt)", e.name, obs(), e.v);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   n;
        rst = 1'b0;
        n   = 0;
        while (bus.heater_on !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        total++;
        if (n < 1 || n > 2) begin
            bad++;
            $display("FAIL basic_heat_latency: got %0d cycles want 1..2", n);
        end
        bus.temp_in = 8'd42;
        push("basic_heating", S_HEAT, 1'b1, 1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        total++;
        if (obs() !== e.v) begin
            bad++;
            $display("FAIL %s: got %b want %b (st,h,f,ack,flt)", e.name, obs(), e.v);
        end
        n = 0;
        while (bus.heater_on === 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        total++;
        if (n < MIN_ON || n > MIN_ON + 1) begin
            bad++;
            $display("FAIL basic_min_on: got %0d cycles want %0d..%0d", n, MIN_ON, MIN_ON + 1);
        end
        push("basic_runout", S_RUN, 1'b0, 1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        total++;
        if (obs() !== e.v) begin
            bad++;
            $display("FAIL %s: got %b want %b (st,h,f,ack,flt)", e.name, obs(), e.v);
        end
        n = 0;
        while (bus.state_out === S_RUN && n < 30) begin
            tick(1);
            n++;
        end
        total++;
        if (n < FAN_RUNOUT || n > FAN_RUNOUT + 1) begin
            bad++;
            $display("FAIL basic_fan_runout: got %0d cycles want %0d..%0d", n, FAN_RUNOUT,
                     FAN_RUNOUT + 1);
        end
        push("basic_off", S_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
        e = exp_q.pop_front();
        total++;
        if (obs() !== e.v) begin
            bad++;
            $display("FAIL %s: got %b want %b (st,h,f,ack,flt)", e.name, obs(), e.v);
        end
    endtask

    task automatic test_hysteresis();
        exp_t e;
        bus.temp_in = 8'd38;
        push("hyst_38_stays_off", S_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(12);
        bus.temp_in = 8'd37;
        push("hyst_37_heats", S_HEAT, 1'b1, 1'b1, 1'b0, 1'b0);
        // First expectation is sampled before temp moved to 37: compare in push order.
        e = exp_q.pop_front();
        total++;
        if (e.v !== {S_OFF, 4'b0000} || obs() !== e.v) begin
            bad++;
            $display("FAIL %s: got %b want %b (st,h,f,ack,flt)", e.name, obs(), e.v);
        end
        tick(1);
        e = exp_q.pop_front();
        total++;
        if (obs() !== e.v) begin
            bad++;
            $display("FAIL %s: got %b want %b (st,h,f,ack,flt)", e.name, obs(), e.v);
        end
        bus.temp_in = 8'd41;
        push("hyst_41_holds", S_HEAT, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(20);
        e = exp_q.pop_front();
        total++;
        if (obs() !== e.v) begin
            bad++;
            $display("FAIL %s: got %b want %b (st,h,f,ack,flt)", e.name, obs(), e.v);
        end
        bus.temp_in = 8'd42;
        push("hyst_42_runout", S_RUN, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1);
        e = exp_q.pop_front();
        total++;
        if (obs() !== e.v) begin
            bad++;
            $display("FAIL %s: got %b want %b (st,h,f,ack,flt)", e.name, obs(), e.v);
        end
        tick(10);
    endtask

    task automatic test_mode_switch();
        exp_t e;
        bus.temp_in = 8'd30;
        tick(20);
        bus.temp_in       = 8'd45;
        bus.selected_mode = 1'b1;
        push("mode_ack_pulse", S_HEAT, 1'b1, 1'b1, 1'b1, 1'b0);
        push("mode_ack_single", S_HEAT, 1'b1, 1'b1, 1'b0, 1'b0);
        push("mode_comfort_holds", S_HEAT, 1'b1, 1'b1, 1'b0, 1'b0);
        push("mode_back_ack", S_HEAT, 1'b1, 1'b1, 1'b1, 1'b0);
        push("mode_eco_runout", S_RUN, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            case (i)
                2: tick(20);
                3: begin
                    bus.selected_mode = 1'b0;
                    tick(1);
                end
                default: tick(1);
            endcase
            e = exp_q.pop_front();
            total++;
            if (obs() !== e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b (st,h,f,ack,flt)", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_enable_drop();
        exp_t e;
        int   n;
        bus.enable  = 1'b0;
        bus.temp_in = 8'd30;
        tick(30);
        bus.enable = 1'b1;
        push("en_heat_start", S_HEAT, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1);
        e = exp_q.pop_front();
        total++;
        if (obs() !== e.v) begin
            bad++;
            $display("FAIL %s: got %b want %b (st,h,f,ack,flt)", e.name, obs(), e.v);
        end
        tick(2);
        bus.enable = 1'b0;
        push("en_drop_runout", S_RUN, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1);
        e = exp_q.pop_front();
        total++;
        if (obs() !== e.v) begin
            bad++;
            $display("FAIL %s: got %b want %b (st,h,f,ack,flt)", e.name, obs(), e.v);
        end
        bus.enable = 1'b1;
        n = 0;
        while (bus.heater_on !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        total++;
        if (n < MIN_OFF || n > MIN_OFF + 1) begin
            bad++;
            $display("FAIL en_min_off: got %0d cycles want %0d..%0d", n, MIN_OFF, MIN_OFF + 1);
        end
    endtask

    task automatic test_boundaries();
        exp_t e;
        bus.setpoint_eco = 8'd255;
        bus.temp_in      = 8'd254;
        push("bnd_255_no_hot_wrap", S_HEAT, 1'b1, 1'b1, 1'b0, 1'b0);
        push("bnd_254_not_cold", S_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
        push("bnd_252_cold", S_HEAT, 1'b1, 1'b1, 1'b0, 1'b0);
        push("bnd_sp0_never_cold", S_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: tick(25);
                1: begin
                    bus.enable = 1'b0;
                    tick(30);
                    bus.enable = 1'b1;
                    tick(3);
                end
                2: begin
                    bus.temp_in = 8'd252;
                    tick(1);
                end
                default: begin
                    bus.setpoint_eco = 8'd0;
                    bus.temp_in      = 8'd0;
                    bus.enable       = 1'b0;
                    tick(1);
                    bus.enable = 1'b1;
                    tick(30);
                end
            endcase
            e = exp_q.pop_front();
            total++;
            if (obs() !== e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b (st,h,f,ack,flt)", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_overtemp();
        exp_t e;
        bus.temp_in = 8'd201;
`ifdef HEAT_OVERTEMP_EN
        push("ot_trip", S_LOCK, 1'b0, 1'b1, 1'b0, 1'b1);
        push("ot_holds", S_LOCK, 1'b0, 1'b1, 1'b0, 1'b1);
        push("ot_rst_clears", S_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: tick(1);
                1: begin
                    bus.temp_in = 8'd20;
                    tick(5);
                end
                default: begin
                    rst = 1'b1;
                    tick(1);
                end
            endcase
            e = exp_q.pop_front();
            total++;
            if (obs() !== e.v) begin
                bad++;
                $display("FAIL %s: got %b want %b (st,h,f,ack,flt)", e.name, obs(), e.v);
            end
        end
        rst = 1'b0;
`else
        push("ot_disabled_no_lockout", S_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        e = exp_q.pop_front();
        total++;
        if (obs() !== e.v) begin
            bad++;
            $display("FAIL %s: got %b want %b (st,h,f,ack,flt)", e.name, obs(), e.v);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_hysteresis();
        test_mode_switch();
        test_enable_drop();
        test_boundaries();
        test_overtemp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
